// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// Results and flags update only on the final RUN edge.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a0;
  logic             b0;
  logic             dbit;
  logic             br_nx;
  logic             last;

  assign a0     = sa[0];
  assign b0     = sb[0];
  assign dbit   = a0 ^ b0 ^ br;
  assign br_nx  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign res_nx = {dbit, res[WIDTH-1:1]};
  assign last   = (state == RUN) && (cnt == LAST);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // On the last bit, sa[0]/sb[0] hold the operand MSBs and dbit is d's MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        sa  <= a;
        sb  <= b;
        br  <= bin;
        res <= '0;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      br  <= br_nx;
      res <= res_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        d    <= res_nx;
        bout <= br_nx;
        ovf  <= (a0 ^ b0) & (dbit ^ a0);
        zero <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8).
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bout;
  logic       ovf;
  logic       zero;

  int total  = 0;
  int passed = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .ovf  (ovf),
    .zero (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia,
                        input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic eb,
                        input logic eo, input logic ez);
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    step();
    start = 1'b0;
    a     = ~ia;
    b     = ~ib;
    bin   = ~ibin;
    check({tag, " busy@E"}, 32'(busy), 32'd1);
    check({tag, " done@E"}, 32'(done), 32'd0);
    repeat (7) step();
    check({tag, " done@E+7"}, 32'(done), 32'd0);
    check({tag, " busy@E+7"}, 32'(busy), 32'd1);
    step();
    check({tag, " done@E+8"}, 32'(done), 32'd1);
    check({tag, " d"}, 32'(d), 32'(ed));
    check({tag, " bout"}, 32'(bout), 32'(eb));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    check({tag, " zero"}, 32'(zero), 32'(ez));
    step();
    check({tag, " done@E+9"}, 32'(done), 32'd0);
    check({tag, " busy@E+9"}, 32'(busy), 32'd0);
    check({tag, " d hold"}, 32'(d), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    bin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst d", 32'(d), 32'd0);
    check("rst bout", 32'(bout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst zero", 32'(zero), 32'd0);
    #9 rst_n = 1'b1;
    step();

    run_op("op1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    a   = 8'hFF;
    b   = 8'h01;
    bin = 1'b1;
    repeat (3) step();
    check("hold d", 32'(d), 32'h02);
    check("hold busy", 32'(busy), 32'd0);

    run_op("op2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op("op3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("op4", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("op5", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("ovfn", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

    // Second start during RUN must be ignored.
    start = 1'b1;
    a     = 8'h05;
    b     = 8'h03;
    bin   = 1'b0;
    step();
    start = 1'b0;
    repeat (2) step();
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h11;
    step();
    start = 1'b0;
    check("ign busy@E+3", 32'(busy), 32'd1);
    repeat (4) step();
    check("ign done@E+7", 32'(done), 32'd0);
    step();
    check("ign busy@E+8", 32'(busy), 32'd1);
    check("ign done@E+8", 32'(done), 32'd1);
    check("ign d", 32'(d), 32'h02);
    step();
    check("ign done@E+9", 32'(done), 32'd0);
    check("ign busy@E+9", 32'(busy), 32'd0);

    // Abort mid-operation with reset.
    start = 1'b1;
    a     = 8'h05;
    b     = 8'h03;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort d", 32'(d), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort no done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post abort idle", 32'({busy, done}), 32'd0);
    end
    check("post abort d", 32'(d), 32'd0);

    run_op("op6", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
